// File: rtl/starship_spawn_ctrl.sv
// Monster-station scheduler for Nexys Starship: LFSR-driven spawns, lane timers, kills, score, game over.
// Optional macro STARSHIP_DIFFICULTY_RAMP_EN shortens the spawn period every 8 kills.
module starship_spawn_ctrl #(
  parameter int unsigned SPAWN_PERIOD = 50000000,
  parameter int unsigned SPAWN_THRESH = 64,
  parameter int unsigned LANE_TIMEOUT = 250000000,
  parameter int unsigned MAX_ACTIVE   = 2,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        play,
  input  logic        restart,
  input  logic [3:0]  kill,
  output logic [3:0]  lane_full,
  output logic [3:0]  spawn_pulse,
  output logic [15:0] score,
  output logic        game_over,
  output logic        q_Init,
  output logic        q_Play,
  output logic        q_Over
);

  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;

  localparam int CW = $clog2(SPAWN_PERIOD);
  localparam int TW = $clog2(LANE_TIMEOUT);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(SPAWN_PERIOD - 1);
  localparam logic [TW-1:0] TIMER_LOAD  = TW'(LANE_TIMEOUT - 1);
  localparam logic [8:0]    THRESH      = 9'(SPAWN_THRESH);
  localparam logic [2:0]    MAX_ACT     = 3'(MAX_ACTIVE);
  // An all-zero seed would lock the LFSR, so it falls back to the default seed.
  localparam logic [15:0]   SEED_EFF    = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  state_t          state;
  logic [15:0]     lfsr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer [4];
  logic [CW-1:0]   period_last;
  logic            tick;
  logic            spawn;
  logic [1:0]      cand;
  logic [3:0]      expire;
  logic [3:0]      valid_kill;
  logic [16:0]     score_sum;
  logic [15:0]     score_next;
  logic            lfsr_fb;

`ifdef STARSHIP_DIFFICULTY_RAMP_EN
  logic [1:0]  level;
  logic [1:0]  level_next;
  logic [31:0] period_eff;

  assign level_next = (|score[15:5]) ? 2'd3 : score[4:3];

  always_comb begin
    period_eff = 32'(SPAWN_PERIOD) >> level;
    if (period_eff == 32'd0) period_eff = 32'd1;
    period_last = CW'(period_eff - 32'd1);
  end

  // Level is latched only at a counter wrap so a period never changes mid-count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      level <= 2'd0;
    end else if (state == S_INIT && play) begin
      level <= 2'd0;
    end else if (tick) begin
      level <= level_next;
    end
  end
`else
  assign period_last = PERIOD_LAST;
`endif

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cand       = lfsr[9:8];
  assign tick       = (state == S_PLAY) && (count == period_last);
  assign spawn      = tick && ({1'b0, lfsr[7:0]} < THRESH) && !lane_full[cand]
                      && (popcount4(lane_full) < MAX_ACT);
  assign valid_kill = kill & lane_full;
  assign score_sum  = {1'b0, score} + {14'b0, popcount4(valid_kill)};
  assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    expire = 4'b0000;
    for (int l = 0; l < 4; l++) begin
      expire[l] = lane_full[l] && (timer[l] == '0) && !kill[l];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= S_INIT;
      lfsr        <= SEED_EFF;
      count       <= '0;
      lane_full   <= 4'b0000;
      spawn_pulse <= 4'b0000;
      score       <= 16'h0000;
      game_over   <= 1'b0;
      q_Init      <= 1'b1;
      q_Play      <= 1'b0;
      q_Over      <= 1'b0;
      // NOTE: the four lane timers are few and their start value matters, so they are reset explicitly.
      for (int l = 0; l < 4; l++) timer[l] <= '0;
    end else begin
      lfsr        <= {lfsr[14:0], lfsr_fb};
      spawn_pulse <= 4'b0000;
      case (state)
        S_INIT: begin
          lane_full <= 4'b0000;
          if (play) begin
            state  <= S_PLAY;
            q_Init <= 1'b0;
            q_Play <= 1'b1;
            score  <= 16'h0000;
            count  <= '0;
            for (int l = 0; l < 4; l++) timer[l] <= '0;
          end
        end

        S_PLAY: begin
          score <= score_next;
          for (int l = 0; l < 4; l++) begin
            if (lane_full[l] && timer[l] != '0) timer[l] <= timer[l] - TW'(1);
          end
          if (|expire) begin
            // Kills in the losing cycle still count, but no new monster appears.
            state     <= S_OVER;
            q_Play    <= 1'b0;
            q_Over    <= 1'b1;
            game_over <= 1'b1;
            lane_full <= lane_full & ~kill;
          end else begin
            count <= tick ? '0 : count + CW'(1);
            if (spawn) begin
              lane_full   <= (lane_full & ~kill) | (4'b0001 << cand);
              spawn_pulse <= 4'b0001 << cand;
              timer[cand] <= TIMER_LOAD;
            end else begin
              lane_full <= lane_full & ~kill;
            end
          end
        end

        S_OVER: begin
          if (restart) begin
            state     <= S_INIT;
            q_Over    <= 1'b0;
            q_Init    <= 1'b1;
            game_over <= 1'b0;
          end
        end

        default: begin
          state     <= S_INIT;
          q_Init    <= 1'b1;
          q_Play    <= 1'b0;
          q_Over    <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_starship_spawn_ctrl.sv
// Bench for starship_spawn_ctrl: three instances checked every cycle against a deadline-based
// reference model, plus directed timing, kill and reset scenarios.
module tb_starship_spawn_ctrl;

  localparam int N  = 3;
  localparam int SP = 4;
  localparam int MI = 0, MP = 1, MO = 2;

  // Instance 0: main config, 1: threshold 0 (never spawns), 2: multi-lane with zero seed.
  int cfg_th [N] = '{256, 0, 160};
  int cfg_lt [N] = '{10, 10, 40};
  int cfg_ma [N] = '{1, 1, 3};

  logic        Clk;
  logic        rst_v     [N];
  logic        play_v    [N];
  logic        restart_v [N];
  logic [3:0]  kill_v    [N];
  logic [3:0]  o_full    [N];
  logic [3:0]  o_pulse   [N];
  logic [15:0] o_score   [N];
  logic        o_over    [N];
  logic        o_qi      [N];
  logic        o_qp      [N];
  logic        o_qo      [N];

  starship_spawn_ctrl #(.SPAWN_PERIOD(SP), .SPAWN_THRESH(256), .LANE_TIMEOUT(10),
                        .MAX_ACTIVE(1), .SEED(16'hACE1)) u_main (
    .Clk(Clk), .Reset(rst_v[0]), .play(play_v[0]), .restart(restart_v[0]), .kill(kill_v[0]),
    .lane_full(o_full[0]), .spawn_pulse(o_pulse[0]), .score(o_score[0]), .game_over(o_over[0]),
    .q_Init(o_qi[0]), .q_Play(o_qp[0]), .q_Over(o_qo[0]));

  starship_spawn_ctrl #(.SPAWN_PERIOD(SP), .SPAWN_THRESH(0), .LANE_TIMEOUT(10),
                        .MAX_ACTIVE(1), .SEED(16'hACE1)) u_never (
    .Clk(Clk), .Reset(rst_v[1]), .play(play_v[1]), .restart(restart_v[1]), .kill(kill_v[1]),
    .lane_full(o_full[1]), .spawn_pulse(o_pulse[1]), .score(o_score[1]), .game_over(o_over[1]),
    .q_Init(o_qi[1]), .q_Play(o_qp[1]), .q_Over(o_qo[1]));

  starship_spawn_ctrl #(.SPAWN_PERIOD(SP), .SPAWN_THRESH(160), .LANE_TIMEOUT(40),
                        .MAX_ACTIVE(3), .SEED(16'h0000)) u_multi (
    .Clk(Clk), .Reset(rst_v[2]), .play(play_v[2]), .restart(restart_v[2]), .kill(kill_v[2]),
    .lane_full(o_full[2]), .spawn_pulse(o_pulse[2]), .score(o_score[2]), .game_over(o_over[2]),
    .q_Init(o_qi[2]), .q_Play(o_qp[2]), .q_Over(o_qo[2]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: lane expiry is tracked as an absolute PLAY-cycle deadline.
  int          m_mode  [N];
  logic [15:0] m_lfsr  [N];
  int          m_idx   [N];
  logic [3:0]  m_full  [N];
  logic [3:0]  m_pulse [N];
  int          m_dead  [N][4];
  int          m_score [N];

  int checks   = 0;
  int failures = 0;
  bit rand0;
  int never_pulses;
  int max_seen;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_mode[i]  = MI;
    m_lfsr[i]  = 16'hACE1;
    m_idx[i]   = 0;
    m_full[i]  = 4'h0;
    m_pulse[i] = 4'h0;
    m_score[i] = 0;
  endtask

  task automatic model_step(input int i);
    logic [15:0] ln;
    logic [3:0]  vk, nf;
    logic [1:0]  c;
    bit          exp_any, tick_m, spawn_m;
    int          s;
    if (!rst_v[i]) begin
      model_reset(i);
      return;
    end
    ln = {m_lfsr[i][14:0], m_lfsr[i][15] ^ m_lfsr[i][13] ^ m_lfsr[i][12] ^ m_lfsr[i][10]};
    m_pulse[i] = 4'h0;
    case (m_mode[i])
      MI: begin
        m_full[i] = 4'h0;
        if (play_v[i]) begin
          m_mode[i]  = MP;
          m_score[i] = 0;
          m_idx[i]   = 0;
        end
      end
      MP: begin
        vk = kill_v[i] & m_full[i];
        exp_any = 1'b0;
        for (int l = 0; l < 4; l++)
          if (m_full[i][l] && m_idx[i] == m_dead[i][l] && !kill_v[i][l]) exp_any = 1'b1;
        s = m_score[i] + $countones(vk);
        m_score[i] = (s > 65535) ? 65535 : s;
        tick_m  = (m_idx[i] % SP) == SP - 1;
        c       = m_lfsr[i][9:8];
        spawn_m = tick_m && (int'(m_lfsr[i][7:0]) < cfg_th[i]) && !m_full[i][c]
                  && ($countones(m_full[i]) < cfg_ma[i]);
        nf = m_full[i] & ~vk;
        if (exp_any) begin
          m_mode[i] = MO;
        end else if (spawn_m) begin
          nf[c]         = 1'b1;
          m_pulse[i][c] = 1'b1;
          m_dead[i][c]  = m_idx[i] + cfg_lt[i];
        end
        m_full[i] = nf;
        m_idx[i]++;
      end
      default: if (restart_v[i]) m_mode[i] = MI;
    endcase
    m_lfsr[i] = ln;
  endtask

  task automatic check_dut(input int i);
    chk("lane_full",   i, o_full[i],  m_full[i]);
    chk("spawn_pulse", i, o_pulse[i], m_pulse[i]);
    chk("score",       i, o_score[i], m_score[i]);
    chk("game_over",   i, o_over[i],  m_mode[i] == MO);
    chk("q_Init",      i, o_qi[i],    m_mode[i] == MI);
    chk("q_Play",      i, o_qp[i],    m_mode[i] == MP);
    chk("q_Over",      i, o_qo[i],    m_mode[i] == MO);
  endtask

  task automatic rand_drive(input int i);
    kill_v[i]    = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
    play_v[i]    = ($urandom_range(0, 3) == 0);
    restart_v[i] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic step();
    if (rand0) rand_drive(0);
    kill_v[1] = 4'($urandom);
    rand_drive(2);
    for (int i = 0; i < N; i++) model_step(i);
    @(posedge Clk);
    #1;
    for (int i = 0; i < N; i++) check_dut(i);
    if (o_pulse[1] != 4'h0) never_pulses++;
    if ($countones(o_full[2]) > max_seen) max_seen = $countones(o_full[2]);
  endtask

  initial begin
    int n, pulses, wait_cycles;
    logic [3:0] frozen;
    rand0 = 1'b0;
    never_pulses = 0;
    max_seen = 0;
    for (int i = 0; i < N; i++) begin
      rst_v[i] = 1'b0;
      play_v[i] = 1'b0;
      restart_v[i] = 1'b0;
      kill_v[i] = 4'h0;
    end
    repeat (3) @(posedge Clk);
    #1;
    for (int i = 0; i < N; i++) begin
      model_reset(i);
      check_dut(i);
    end
    for (int i = 0; i < N; i++) rst_v[i] = 1'b1;

    wait_cycles = $urandom_range(1, 20);
    repeat (wait_cycles) step();

    // First game: spawn latency, expiry latency, frozen OVER, restart.
    play_v[0] = 1'b1;
    play_v[1] = 1'b1;
    step();
    play_v[0] = 1'b0;
    play_v[1] = 1'b0;
    chk("play_entered", 0, o_qp[0], 1);
    n = 0;
    while (o_pulse[0] == 4'h0 && n < 20) begin step(); n++; end
    chk("first_spawn_edge", 0, n, 4);
    chk("one_lane_full", 0, $countones(o_full[0]), 1);
    n = 0;
    pulses = 0;
    while (!o_over[0] && n < 30) begin
      step();
      n++;
      if (o_pulse[0] != 4'h0) pulses++;
    end
    chk("over_latency", 0, n, 10);
    chk("no_extra_spawn", 0, pulses, 0);
    chk("over_q", 0, o_qo[0], 1);
    frozen = m_full[0];
    kill_v[0] = 4'hF;
    play_v[0] = 1'b1;
    step();
    step();
    kill_v[0] = 4'h0;
    play_v[0] = 1'b0;
    chk("over_frozen_full", 0, o_full[0], frozen);
    chk("over_frozen_score", 0, o_score[0], 0);
    restart_v[0] = 1'b1;
    step();
    restart_v[0] = 1'b0;
    chk("restart_init", 0, o_qi[0], 1);
    chk("restart_no_over", 0, o_over[0], 0);

    // Second game: kill 3 cycles after spawn, empty-lane kill, kill at timer zero.
    play_v[0] = 1'b1;
    step();
    play_v[0] = 1'b0;
    n = 0;
    while (o_pulse[0] == 4'h0 && n < 20) begin step(); n++; end
    chk("second_spawn_edge", 0, n, 4);
    step();
    step();
    kill_v[0] = m_full[0];
    step();
    kill_v[0] = 4'h0;
    chk("kill_clears", 0, o_full[0], 0);
    chk("kill_score", 0, o_score[0], 1);
    kill_v[0] = 4'hF;
    step();
    kill_v[0] = 4'h0;
    chk("empty_kill_score", 0, o_score[0], 1);
    n = 0;
    while (o_pulse[0] == 4'h0 && n < 20) begin step(); n++; end
    repeat (9) step();
    kill_v[0] = m_full[0];
    step();
    kill_v[0] = 4'h0;
    chk("zero_timer_kill_no_over", 0, o_over[0], 0);
    chk("zero_timer_kill_score", 0, o_score[0], 2);
    chk("zero_timer_kill_clear", 0, o_full[0], 0);

    // Random phase; instance 1 stays in PLAY for well over 100 ticks.
    rand0 = 1'b1;
    repeat (450) step();
    chk("never_spawn_pulses", 1, never_pulses, 0);
    chk("never_still_play", 1, o_qp[1], 1);
    chk("multi_cap", 2, max_seen <= 3, 1);

    // Asynchronous reset with several lanes occupied.
    n = 0;
    while (!($countones(m_full[2]) >= 2 && m_mode[2] == MP) && n < 300) begin step(); n++; end
    chk("multi_two_lanes", 2, $countones(o_full[2]) >= 2, 1);
    for (int i = 0; i < N; i++) rst_v[i] = 1'b0;
    #1;
    chk("rst_full", 2, o_full[2], 0);
    chk("rst_pulse", 2, o_pulse[2], 0);
    chk("rst_score", 2, o_score[2], 0);
    chk("rst_over", 2, o_over[2], 0);
    chk("rst_q_init", 2, o_qi[2], 1);
    chk("rst_q_play", 2, o_qp[2], 0);
    for (int i = 0; i < N; i++) begin
      model_reset(i);
      check_dut(i);
    end
    step();
    step();
    for (int i = 0; i < N; i++) rst_v[i] = 1'b1;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
